// File: rtl/spi_tx_packet_streamer_pkg.sv
// Shared NDN packet definitions for the SPI transmit streamer: packet layout,
// field widths, streamer state encoding and byte-select helpers.
package ndn_pkt_pkg;

    localparam int META_TYPE_BIT = 6;
    localparam logic PKT_INTEREST = 1'b1;
    localparam logic PKT_DATA     = 1'b0;

    localparam int PREFIX_BYTES = 8;
    localparam int DATA_BYTES   = 32;

    localparam int META_W     = 8;
    localparam int PLEN_W     = 6;
    localparam int PREFIX_W   = PREFIX_BYTES * 8;
    localparam int DATA_W     = DATA_BYTES * 8;
    localparam int PKT_W      = META_W + PREFIX_W + DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_META   = 3'd2,
        ST_PREFIX = 3'd3,
        ST_GAP    = 3'd4,
        ST_DATA   = 3'd5,
        ST_HOLD   = 3'd6
    } stream_state_e;

    typedef struct packed {
        logic [META_W-1:0]   meta;
        logic [PREFIX_W-1:0] prefix;
        logic [DATA_W-1:0]   data;
    } ndn_pkt_t;

    // Index 0 selects the most significant byte; ~idx is (count-1-idx) for power-of-two counts.
    function automatic logic [7:0] prefix_byte(input logic [PREFIX_W-1:0] prefix, input logic [2:0] idx);
        return prefix[{~idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] data_byte(input logic [DATA_W-1:0] data, input logic [4:0] idx);
        return data[{~idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_tx_packet_streamer_if.sv
// Packet-in / byte-stream-out bundle between the forwarding logic, the
// streamer and the SPI interface.
interface spi_tx_packet_streamer_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_meta;
    logic [63:0]  in_prefix;
    logic [255:0] in_data;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         busy;
    logic         pkt_sent;

    modport master (
        output in_valid, in_meta, in_prefix, in_data,
        input  in_ready, tx_valid, tx_byte, busy, pkt_sent
    );

    modport slave (
        input  in_valid, in_meta, in_prefix, in_data,
        output in_ready, tx_valid, tx_byte, busy, pkt_sent
    );
endinterface

// File: rtl/spi_tx_packet_streamer_skid.sv
// One-entry valid/ready holding register; ready is registered and depends
// only on occupancy, so there is no combinational path from in_valid.
module ndn_pkt_skid_reg #(
    parameter int W = 328
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         in_ready,
    input  logic         take,
    output logic         out_valid,
    output logic [W-1:0] out_payload
);

    logic         valid_r;
    logic         ready_r;
    logic [W-1:0] payload_r;
    logic         load_s;
    logic         valid_n_s;

    assign load_s      = in_valid && ready_r;
    assign in_ready    = ready_r;
    assign out_valid   = valid_r;
    assign out_payload = payload_r;

    // Next occupancy: a load wins over a drain on the same edge.
    always_comb begin
        valid_n_s = valid_r;
        if (load_s) begin
            valid_n_s = 1'b1;
        end else if (take) begin
            valid_n_s = 1'b0;
        end else begin
            valid_n_s = valid_r;
        end
    end

    // Occupancy, registered ready and payload storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r   <= 1'b0;
            ready_r   <= 1'b1;
            payload_r <= {W{1'b0}};
        end else begin
            valid_r <= valid_n_s;
            ready_r <= !valid_n_s;
            if (load_s) begin
                payload_r <= in_payload;
            end
        end
    end

endmodule

// File: rtl/spi_tx_packet_streamer.sv
// Streams one buffered NDN packet as start pulse + meta + prefix + gap + 32
// data bytes, then holds off while the SPI link shifts the bits out.
module spi_tx_packet_streamer
    import ndn_pkt_pkg::*;
#(
    parameter int HOLDOFF_INT  = 80,
    parameter int HOLDOFF_DATA = 340
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_tx_packet_streamer_if.slave  bus
);

    localparam int HOLD_MAX = (HOLDOFF_INT > HOLDOFF_DATA) ? HOLDOFF_INT : HOLDOFF_DATA;
    localparam int HCNT_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HCNT_W-1:0] HOLD_INT_LD  = HCNT_W'(HOLDOFF_INT);
    localparam logic [HCNT_W-1:0] HOLD_DATA_LD = HCNT_W'(HOLDOFF_DATA);
    localparam logic [HCNT_W-1:0] HCNT_ONE     = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] HCNT_ZERO    = HCNT_W'(0);

    stream_state_e     state_r, state_n;
    logic [2:0]        pidx_r, pidx_n;
    logic [4:0]        didx_r, didx_n;
    logic [HCNT_W-1:0] hcnt_r, hcnt_n;
    ndn_pkt_t          work_r;
    ndn_pkt_t          in_pkt_s;
    ndn_pkt_t          skid_pkt_s;
    logic              skid_valid_s;
    logic              take_s;

    logic              tx_valid_r, tx_valid_n;
    logic [7:0]        tx_byte_r, tx_byte_n;
    logic              busy_r, busy_n;
    logic              pkt_sent_r, pkt_sent_n;

    // Interest packets carry no payload, so their data field is stored as zeros.
    always_comb begin
        in_pkt_s.meta   = bus.in_meta;
        in_pkt_s.prefix = bus.in_prefix;
        if (bus.in_meta[META_TYPE_BIT] == PKT_INTEREST) begin
            in_pkt_s.data = {DATA_W{1'b0}};
        end else begin
            in_pkt_s.data = bus.in_data;
        end
    end

    assign take_s = (state_r == ST_IDLE) && skid_valid_s;

    ndn_pkt_skid_reg #(
        .W (PKT_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (bus.in_valid),
        .in_payload  (in_pkt_s),
        .in_ready    (bus.in_ready),
        .take        (take_s),
        .out_valid   (skid_valid_s),
        .out_payload (skid_pkt_s)
    );

    // Next-state and counter sequencing.
    always_comb begin
        state_n = state_r;
        pidx_n  = pidx_r;
        didx_n  = didx_r;
        hcnt_n  = hcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (skid_valid_s) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: state_n = ST_META;
            ST_META: begin
                state_n = ST_PREFIX;
                pidx_n  = 3'd0;
            end
            ST_PREFIX: begin
                if (pidx_r == 3'd7) begin
                    state_n = ST_GAP;
                end else begin
                    pidx_n = pidx_r + 3'd1;
                end
            end
            ST_GAP: begin
                state_n = ST_DATA;
                didx_n  = 5'd0;
            end
            ST_DATA: begin
                if (didx_r == 5'd31) begin
                    state_n = ST_HOLD;
                    if (work_r.meta[META_TYPE_BIT] == PKT_INTEREST) begin
                        hcnt_n = HOLD_INT_LD;
                    end else begin
                        hcnt_n = HOLD_DATA_LD;
                    end
                end else begin
                    didx_n = didx_r + 5'd1;
                end
            end
            ST_HOLD: begin
                if (hcnt_r == HCNT_ZERO) begin
                    state_n = ST_IDLE;
                end else begin
                    hcnt_n = hcnt_r - HCNT_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered so they can be registered.
    always_comb begin
        tx_valid_n = 1'b0;
        tx_byte_n  = 8'h00;
        pkt_sent_n = 1'b0;
        busy_n     = (state_n != ST_IDLE);
        case (state_n)
            ST_START:  tx_valid_n = 1'b1;
            ST_META:   tx_byte_n  = work_r.meta;
            ST_PREFIX: tx_byte_n  = prefix_byte(work_r.prefix, pidx_n);
            ST_DATA:   tx_byte_n  = data_byte(work_r.data, didx_n);
            ST_HOLD:   pkt_sent_n = (hcnt_n == HCNT_ZERO);
            default:   tx_byte_n  = 8'h00;
        endcase
    end

    // State, counters, working packet and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            pidx_r     <= 3'd0;
            didx_r     <= 5'd0;
            hcnt_r     <= HCNT_ZERO;
            work_r     <= {PKT_W{1'b0}};
            tx_valid_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            busy_r     <= 1'b0;
            pkt_sent_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            pidx_r     <= pidx_n;
            didx_r     <= didx_n;
            hcnt_r     <= hcnt_n;
            tx_valid_r <= tx_valid_n;
            tx_byte_r  <= tx_byte_n;
            busy_r     <= busy_n;
            pkt_sent_r <= pkt_sent_n;
            if (take_s) begin
                work_r <= skid_pkt_s;
            end
        end
    end

    assign bus.tx_valid = tx_valid_r;
    assign bus.tx_byte  = tx_byte_r;
    assign bus.busy     = busy_r;
    assign bus.pkt_sent = pkt_sent_r;

endmodule

// File: tb/tb_spi_tx_packet_streamer.sv
// Bench for spi_tx_packet_streamer: two instances (default hold-off and
// HOLDOFF_DATA=0) share stimulus and are checked every cycle against a
// packet-timeline model, plus literal timing/byte expectations.
module tb_spi_tx_packet_streamer;

    typedef struct packed {
        logic [7:0]   meta;
        logic [63:0]  prefix;
        logic [255:0] data;
    } pkt_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         drv_valid = 1'b0;
    logic [7:0]   drv_meta = 8'h00;
    logic [63:0]  drv_prefix = 64'h0;
    logic [255:0] drv_data = 256'h0;

    spi_tx_packet_streamer_if if0();
    spi_tx_packet_streamer_if if1();

    assign if0.in_valid  = drv_valid;
    assign if0.in_meta   = drv_meta;
    assign if0.in_prefix = drv_prefix;
    assign if0.in_data   = drv_data;
    assign if1.in_valid  = drv_valid;
    assign if1.in_meta   = drv_meta;
    assign if1.in_prefix = drv_prefix;
    assign if1.in_data   = drv_data;

    spi_tx_packet_streamer #(.HOLDOFF_INT(80), .HOLDOFF_DATA(340)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    spi_tx_packet_streamer #(.HOLDOFF_INT(80), .HOLDOFF_DATA(0))   dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial forever #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   m_on = 1'b0;
    bit   m_active [2];
    bit   m_full [2];
    int   m_t [2];
    pkt_t m_cur [2];
    pkt_t m_skid [2];
    int   hold_data [2] = '{340, 0};
    int   starts0[$], starts1[$], sents0[$], sents1[$];
    logic [7:0] blog0 [0:16383];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int hold_of(input pkt_t p, input int i);
        return p.meta[6] ? 80 : hold_data[i];
    endfunction

    // Byte on the bus t cycles after the start pulse.
    function automatic logic [7:0] exp_byte(input pkt_t p, input int t);
        logic [255:0] w;
        if (t == 1) return p.meta;
        if (t >= 2 && t <= 9) begin
            w = {192'd0, p.prefix} >> (8 * (9 - t));
            return w[7:0];
        end
        if (t >= 11 && t <= 42 && !p.meta[6]) begin
            w = p.data >> (8 * (42 - t));
            return w[7:0];
        end
        return 8'h00;
    endfunction

    task automatic cmp_inst(input int i, input logic v, input logic [7:0] b,
                            input logic bz, input logic s, input logic r);
        bit a;
        int t;
        a = m_active[i];
        t = m_t[i];
        chk($sformatf("tx_valid%0d", i), 64'(v), 64'(a && t == 0));
        chk($sformatf("tx_byte%0d", i), 64'(b), 64'(a ? exp_byte(m_cur[i], t) : 8'h00));
        chk($sformatf("busy%0d", i), 64'(bz), 64'(a));
        chk($sformatf("pkt_sent%0d", i), 64'(s), 64'(a && t == 43 + hold_of(m_cur[i], i)));
        chk($sformatf("in_ready%0d", i), 64'(r), 64'(!m_full[i]));
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic step_model();
        bit acc;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_active[i] = 1'b0;
                m_full[i]   = 1'b0;
                m_t[i]      = 0;
            end else begin
                acc = drv_valid && !m_full[i];
                if (m_active[i]) begin
                    if (m_t[i] == 43 + hold_of(m_cur[i], i)) m_active[i] = 1'b0;
                    else m_t[i] = m_t[i] + 1;
                end else if (m_full[i]) begin
                    m_cur[i]    = m_skid[i];
                    m_full[i]   = 1'b0;
                    m_active[i] = 1'b1;
                    m_t[i]      = 0;
                end
                if (acc) begin
                    m_skid[i] = '{drv_meta, drv_prefix, drv_data};
                    m_full[i] = 1'b1;
                end
            end
        end
        if (!rst) m_on = 1'b1;
    endtask

    // Compare, log events, then step the model; runs mid-cycle away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_on) begin
            cmp_inst(0, if0.tx_valid, if0.tx_byte, if0.busy, if0.pkt_sent, if0.in_ready);
            cmp_inst(1, if1.tx_valid, if1.tx_byte, if1.busy, if1.pkt_sent, if1.in_ready);
        end
        if (if0.tx_valid === 1'b1) starts0.push_back(cyc);
        if (if1.tx_valid === 1'b1) starts1.push_back(cyc);
        if (if0.pkt_sent === 1'b1) sents0.push_back(cyc);
        if (if1.pkt_sent === 1'b1) sents1.push_back(cyc);
        if (cyc < 16384) blog0[cyc] = if0.tx_byte;
        step_model();
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] m, input logic [63:0] p, input logic [255:0] d);
        int n;
        drv_meta = m; drv_prefix = p; drv_data = d; drv_valid = 1'b1;
        n = 0;
        while (if0.in_ready !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("send_accept_bound", 64'(n < 3000), 64'd1);
        tick();
        drv_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(if0.busy === 1'b0 && if1.busy === 1'b0 && if0.in_ready === 1'b1 &&
                 if1.in_ready === 1'b1) && n < 5000) begin
            tick();
            n++;
        end
        chk("idle_bound", 64'(n < 5000), 64'd1);
    endtask

    task automatic wait_sent0(input int k);
        int n;
        n = 0;
        while (sents0.size() < k && n < 3000) begin
            tick();
            n++;
        end
        chk("pkt_sent_bound", 64'(sents0.size() >= k), 64'd1);
    endtask

    logic [255:0] ramp;
    int T, n0, ns0;
    logic [7:0] orv;

    initial begin
        for (int k = 0; k < 32; k++) ramp = {ramp[247:0], 8'(k)};
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("reset_in_ready", 64'(if0.in_ready), 64'd1);
        chk("reset_tx_byte", 64'(if0.tx_byte), 64'h0);

        // Single data packet
        send(8'h0A, 64'h0123456789ABCDEF, ramp);
        wait_sent0(1);
        if (sents0.size() >= 1 && starts0.size() >= 1 && starts1.size() >= 1 && sents1.size() >= 1) begin
            T = starts0[0];
            chk("A_meta", 64'(blog0[T + 1]), 64'h0A);
            chk("A_prefix_first", 64'(blog0[T + 2]), 64'h01);
            chk("A_prefix_second", 64'(blog0[T + 3]), 64'h23);
            chk("A_prefix_last", 64'(blog0[T + 9]), 64'hEF);
            chk("A_gap", 64'(blog0[T + 10]), 64'h00);
            chk("A_data_first", 64'(blog0[T + 11]), 64'h00);
            chk("A_data_last", 64'(blog0[T + 42]), 64'h1F);
            chk("A_sent_delay", 64'(sents0[0] - T), 64'd383);
            chk("A_sent_delay_h0", 64'(sents1[0] - starts1[0]), 64'd43);
        end
        wait_idle();

        // Interest packet: payload must be suppressed
        send(8'h48, 64'hFEDCBA9876543210, {32{8'hA5}});
        wait_sent0(2);
        wait_idle();
        if (starts0.size() >= 2 && sents0.size() >= 2 && sents1.size() >= 2) begin
            T = starts0[1];
            orv = 8'h00;
            for (int k = 11; k <= 42; k++) orv = orv | blog0[T + k];
            chk("B_data_zero", 64'(orv), 64'h0);
            chk("B_meta", 64'(blog0[T + 1]), 64'h48);
            chk("B_sent_delay", 64'(sents0[1] - T), 64'd123);
            chk("B_sent_delay_h0", 64'(sents1[1] - starts1[1]), 64'd123);
        end

        // Back-to-back plus stall with changing inputs while the skid is full
        send(8'h8A, 64'h1122334455667788, ramp);
        send(8'h11, 64'h99AABBCCDDEEFF00, ~ramp);
        drv_valid = 1'b1;
        for (int c = 0; c < 500; c++) begin
            drv_meta   = 8'($urandom_range(0, 255));
            drv_prefix = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) drv_data = {drv_data[223:0], $urandom};
            tick();
        end
        drv_valid = 1'b0;
        wait_idle();
        if (starts0.size() >= 4 && sents0.size() >= 3 && starts1.size() >= 4) begin
            chk("C_meta_bit7", 64'(blog0[starts0[2] + 1]), 64'h8A);
            chk("C_sent_delay", 64'(sents0[2] - starts0[2]), 64'd383);
            chk("D_start_after_C_sent", 64'(starts0[3] - sents0[2]), 64'd2);
            chk("D_prefix_first", 64'(blog0[starts0[3] + 2]), 64'h99);
            chk("D_start_spacing_h0", 64'(starts1[3] - starts1[2]), 64'd45);
        end

        // Reset in the middle of the data phase
        n0 = starts0.size();
        ns0 = sents0.size();
        send(8'h0A, 64'h0123456789ABCDEF, ramp);
        begin
            int n;
            n = 0;
            while (starts0.size() <= n0 && n < 100) begin
                tick();
                n++;
            end
            chk("F_start_bound", 64'(starts0.size() > n0), 64'd1);
        end
        if (starts0.size() > n0) begin
            T = starts0[n0];
            repeat (19) tick();
            rst = 1'b0;
            tick();
            rst = 1'b1;
            repeat (30) tick();
            chk("F_byte_before_rst", 64'(blog0[T + 20]), 64'h09);
            chk("F_byte_after_rst", 64'(blog0[T + 21]), 64'h00);
            chk("F_no_pkt_sent", 64'(sents0.size()), 64'(ns0));
        end
        wait_idle();

        // Fresh packet after the abort
        n0 = starts0.size();
        send(8'h0A, 64'h0123456789ABCDEF, ramp);
        wait_sent0(ns0 + 1);
        wait_idle();
        if (starts0.size() > n0 && sents0.size() > ns0) begin
            T = starts0[n0];
            chk("G_prefix_first", 64'(blog0[T + 2]), 64'h01);
            chk("G_data_last", 64'(blog0[T + 42]), 64'h1F);
            chk("G_sent_delay", 64'(sents0[ns0] - T), 64'd383);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
